// File: rtl/arbiter_wrr_pkg.sv
// Shared types, constants and helper functions for the weighted round-robin arbiter.
package arbiter_wrr_pkg;

  // Arbiter state: no owner, or a port currently holds the resource.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Quota latched at reset and used in place of a programmed quota of zero.
  localparam int DEFAULT_QUOTA = 1;

  // Smallest index width that can address n ports (at least one bit).
  function automatic int id_width_for(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

  // Port reached by stepping 'off' places from 'base' around a ring of n ports.
  function automatic int rot_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/arbiter_wrr_rr_pick.sv
// Combinational round-robin picker: finds the first requesting port at or after ptr.
// The request vector is rotated so ptr lands at position 0, priority-encoded,
// and the resulting offset is rotated back into an absolute port index.
module arbiter_rr_pick
  import arbiter_wrr_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int ID_WIDTH  = 3
) (
  input  logic [0:NUM_PORTS-1] request,
  input  logic [ID_WIDTH-1:0]  ptr,
  output logic                 found,
  output logic [ID_WIDTH-1:0]  winner,
  output logic [0:NUM_PORTS-1] winner_onehot
);

  logic [0:NUM_PORTS-1] rotated;
  logic [ID_WIDTH-1:0]  offset;
  int                   win_idx;

  // Rotate the requests so the port at ptr becomes position 0.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rotated[i] = request[rot_index(int'(ptr), i, NUM_PORTS)];
    end
  end

  // Priority-encode the rotated vector; the lowest set position wins.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = i[ID_WIDTH-1:0];
      end
    end
  end

  // Undo the rotation to get the absolute winner and its one-hot form.
  always_comb begin
    win_idx       = rot_index(int'(ptr), int'(offset), NUM_PORTS);
    winner        = win_idx[ID_WIDTH-1:0];
    winner_onehot = '0;
    if (found) begin
      winner_onehot[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter. A winning port keeps the grant for up to its
// quota of consecutive cycles while it keeps requesting; priority then rotates
// to the port after the winner. All outputs come straight from registers.
module arbiter_wrr
  import arbiter_wrr_pkg::*;
#(
  parameter int NUM_PORTS   = 6,
  parameter int QUOTA_WIDTH = 4,
  parameter int ID_WIDTH    = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [0:NUM_PORTS-1]             request,
  input  logic [NUM_PORTS*QUOTA_WIDTH-1:0] quota,
  output logic [0:NUM_PORTS-1]             grant,
  output logic [ID_WIDTH-1:0]              grant_id,
  output logic                             active,
  output logic                             last
);

  arb_state_t             state;
  logic [ID_WIDTH-1:0]    ptr;
  logic [QUOTA_WIDTH-1:0] cnt;
  logic [QUOTA_WIDTH-1:0] qlat;

  logic                   pick_found;
  logic [ID_WIDTH-1:0]    pick_id;
  logic [0:NUM_PORTS-1]   pick_onehot;

  logic                   own_keep;
  logic [QUOTA_WIDTH-1:0] cnt_inc;
  logic [QUOTA_WIDTH-1:0] pick_quota_raw;
  logic [QUOTA_WIDTH-1:0] pick_quota;
  logic [ID_WIDTH-1:0]    ptr_after;

  arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_pick (
    .request       (request),
    .ptr           (ptr),
    .found         (pick_found),
    .winner        (pick_id),
    .winner_onehot (pick_onehot)
  );

  // Next-state helpers: tenure continuation, winner quota and the rotated pointer.
  always_comb begin
    own_keep       = (state == ST_OWN) && request[grant_id] && (cnt < qlat);
    cnt_inc        = cnt + 1'b1;
    pick_quota_raw = quota[int'(pick_id)*QUOTA_WIDTH +: QUOTA_WIDTH];
    pick_quota     = (pick_quota_raw == '0) ? QUOTA_WIDTH'(DEFAULT_QUOTA) : pick_quota_raw;
    ptr_after      = (pick_id == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : pick_id + 1'b1;
  end

  // Arbitration FSM with registered grant outputs, tenure counter and search pointer.
  // Disabling only drops the grant; ptr and cnt are left alone so the search
  // resumes from where it was once enable returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      last     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
      qlat     <= QUOTA_WIDTH'(DEFAULT_QUOTA);
    end else if (!enable) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      last     <= 1'b0;
    end else if (own_keep) begin
      cnt      <= cnt_inc;
      last     <= (cnt_inc == qlat);
    end else if (pick_found) begin
      state    <= ST_OWN;
      grant    <= pick_onehot;
      grant_id <= pick_id;
      active   <= 1'b1;
      last     <= (pick_quota == QUOTA_WIDTH'(1));
      cnt      <= QUOTA_WIDTH'(1);
      qlat     <= pick_quota;
      ptr      <= ptr_after;
    end else begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      last     <= 1'b0;
    end
  end

  // Output invariants: at most one grant, active mirrors the grant, last only while granted.
  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_active_match : assert property (@(posedge clk) disable iff (rst) active == (|grant));
  a_last_active  : assert property (@(posedge clk) disable iff (rst) !last || active);

endmodule
